// File: rtl/lzy_fsm_seqdet.sv
// lzy_fsm_seqdet: parametrised serial sequence detector.
// Finds a LEN-bit PATTERN in a qualified serial stream, with overlapping or
// non-overlapping detection. It drives a registered one-cycle match pulse and
// keeps a saturating count of matches.
// Optional build macro LZY_SEQDET_PROG_EN: adds pat_load/pat_in so the pattern
// can be changed at run time through the pat_r register.
module lzy_fsm_seqdet #(
  parameter int unsigned    LEN     = 3,
  parameter logic [LEN-1:0] PATTERN = 3'b100,
  parameter int unsigned    CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ina,
  input  logic             in_valid,
  input  logic             mode_ovl,
  input  logic             cnt_clr,
`ifdef LZY_SEQDET_PROG_EN
  input  logic             pat_load,
  input  logic [LEN-1:0]   pat_in,
`endif
  output logic             dataout,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int unsigned          FILL_W    = $clog2(LEN + 1);
  localparam logic [FILL_W-1:0]    FILL_FULL = FILL_W'(LEN);
  localparam logic [CNT_W-1:0]     CNT_MAX   = '1;

  // FILLING while fewer than LEN valid bits are held; ARMED once the window is full.
  typedef enum logic {FILLING, ARMED} phase_e;

  logic [LEN-1:0]    hist, hist_d, hist_n;
  logic [FILL_W-1:0] fill, fill_d, fill_inc;
  logic [CNT_W-1:0]  cnt_d;
  logic              dataout_d;
  logic              match;
  logic [LEN-1:0]    pat_cur;
  phase_e            phase;

  assign phase = (fill == FILL_FULL) ? ARMED : FILLING;

`ifdef LZY_SEQDET_PROG_EN
  logic [LEN-1:0] pat_r, pat_d;

  assign pat_cur = pat_r;

  // The pattern register: after reset it holds the PATTERN parameter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pat_r <= PATTERN;
    else      pat_r <= pat_d;
  end
`else
  assign pat_cur = PATTERN;
`endif

  // The state register: history, fill level, match pulse and match counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist      <= '0;
      fill      <= '0;
      dataout   <= 1'b0;
      match_cnt <= '0;
    end else begin
      // NOTE: use non-blocking assignments for all flops. Each register then
      // sees the values from before the edge, whatever order the lines are in.
      hist      <= hist_d;
      fill      <= fill_d;
      dataout   <= dataout_d;
      match_cnt <= cnt_d;
    end
  end

  // Next-state logic: shift in a valid bit, detect a match, restart or clear.
  always_comb begin
    // NOTE: every signal gets a default here, before any branch. A path that
    // left a signal unassigned would infer a latch.
    hist_d    = hist;
    fill_d    = fill;
    dataout_d = 1'b0;
    match     = 1'b0;
    hist_n    = {hist[LEN-2:0], ina};
    fill_inc  = (phase == ARMED) ? fill : fill + FILL_W'(1);
`ifdef LZY_SEQDET_PROG_EN
    pat_d     = pat_r;
    if (pat_load) begin
      // A new pattern discards the partial history and any bit sampled on this edge.
      pat_d  = pat_in;
      hist_d = '0;
      fill_d = '0;
    end else
`endif
    if (in_valid) begin
      match     = (fill_inc == FILL_FULL) && (hist_n == pat_cur);
      hist_d    = hist_n;
      fill_d    = (match && !mode_ovl) ? '0 : fill_inc;
      dataout_d = match;
    end

    // A clear wins over a coincident match. The count sticks at all-ones.
    if (cnt_clr)                            cnt_d = '0;
    else if (match && match_cnt != CNT_MAX) cnt_d = match_cnt + CNT_W'(1);
    else                                    cnt_d = match_cnt;
  end

endmodule

// File: tb/tb_lzy_fsm_seqdet.sv
// Testbench for lzy_fsm_seqdet. Three instances share one input stream:
// the default build, LEN=4 with pattern 1010, and CNT_W=2. A reference model
// keeps the list of valid bits seen since the last restart. After each edge
// it pushes the expected outputs into a scoreboard, and a monitor checks them
// on the falling edge.
module tb_lzy_fsm_seqdet;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, ina, in_valid, mode_ovl, cnt_clr;
`ifdef LZY_SEQDET_PROG_EN
  logic       pat_load;
  logic [2:0] pat_in3;
  logic [3:0] pat_in4;
`endif
  logic       d0, d1, d2;
  logic [7:0] c0, c1;
  logic [1:0] c2;

  lzy_fsm_seqdet u_def (
    .clk(clk), .rst(rst), .ina(ina), .in_valid(in_valid), .mode_ovl(mode_ovl),
    .cnt_clr(cnt_clr),
`ifdef LZY_SEQDET_PROG_EN
    .pat_load(pat_load), .pat_in(pat_in3),
`endif
    .dataout(d0), .match_cnt(c0));

  lzy_fsm_seqdet #(.LEN(4), .PATTERN(4'b1010)) u_l4 (
    .clk(clk), .rst(rst), .ina(ina), .in_valid(in_valid), .mode_ovl(mode_ovl),
    .cnt_clr(cnt_clr),
`ifdef LZY_SEQDET_PROG_EN
    .pat_load(pat_load), .pat_in(pat_in4),
`endif
    .dataout(d1), .match_cnt(c1));

  lzy_fsm_seqdet #(.CNT_W(2)) u_c2 (
    .clk(clk), .rst(rst), .ina(ina), .in_valid(in_valid), .mode_ovl(mode_ovl),
    .cnt_clr(cnt_clr),
`ifdef LZY_SEQDET_PROG_EN
    .pat_load(pat_load), .pat_in(pat_in3),
`endif
    .dataout(d2), .match_cnt(c2));

  typedef struct packed {
    logic       d0, d1, d2;
    logic [7:0] c0, c1, c2;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // Reference model state, one entry per instance.
  int          len_m[3]  = '{3, 4, 3};
  logic [15:0] pdef_m[3] = '{16'h4, 16'hA, 16'h4};
  int          cmax_m[3] = '{255, 255, 3};
  logic [15:0] pat_m[3];
  int          nseen[3];
  bit          seen[3][4096];
  int          cnt_m[3];
  bit          d_m[3];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // True when the most recent len_m[k] bits since the restart spell the pattern.
  function automatic bit tail_match(input int k);
    if (nseen[k] < len_m[k]) return 1'b0;
    for (int i = 0; i < len_m[k]; i++)
      if (seen[k][nseen[k] - len_m[k] + i] != pat_m[k][len_m[k] - 1 - i]) return 1'b0;
    return 1'b1;
  endfunction

  // Apply the inputs of the coming edge to the model, then queue the expected result.
  task automatic model_step();
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      bit m;
      bit load;
      m    = 1'b0;
      load = 1'b0;
      if (!rst) begin
        nseen[k] = 0;
        cnt_m[k] = 0;
        pat_m[k] = pdef_m[k];
      end else begin
`ifdef LZY_SEQDET_PROG_EN
        if (pat_load) begin
          load     = 1'b1;
          pat_m[k] = (k == 1) ? 16'(pat_in4) : 16'(pat_in3);
          nseen[k] = 0;
        end
`endif
        if (!load && in_valid) begin
          seen[k][nseen[k]] = ina;
          nseen[k]++;
          m = tail_match(k);
          if (m && !mode_ovl) nseen[k] = 0;
        end
        if (cnt_clr)                     cnt_m[k] = 0;
        else if (m && cnt_m[k] < cmax_m[k]) cnt_m[k]++;
      end
      d_m[k] = m;
    end
    e.d0 = d_m[0]; e.d1 = d_m[1]; e.d2 = d_m[2];
    e.c0 = 8'(cnt_m[0]); e.c1 = 8'(cnt_m[1]); e.c2 = 8'(cnt_m[2]);
    sb.push_back(e);
  endtask

  task automatic drive(input logic r, input logic a, input logic v,
                       input logic o, input logic c);
    @(negedge clk);
    #1;
    rst = r; ina = a; in_valid = v; mode_ovl = o; cnt_clr = c;
`ifdef LZY_SEQDET_PROG_EN
    pat_load = 1'b0;
`endif
    model_step();
  endtask

`ifdef LZY_SEQDET_PROG_EN
  task automatic drive_load(input logic [2:0] p3, input logic [3:0] p4);
    @(negedge clk);
    #1;
    rst = 1'b1; ina = 1'b1; in_valid = 1'b1; mode_ovl = 1'b0; cnt_clr = 1'b0;
    pat_load = 1'b1; pat_in3 = p3; pat_in4 = p4;
    model_step();
  endtask
`endif

  // Feed a string of valid bits, in order, from a sequence literal.
  task automatic stream(input logic [15:0] bits, input int n, input logic o);
    for (int i = n - 1; i >= 0; i--) drive(1'b1, bits[i], 1'b1, o, 1'b0);
  endtask

  // Monitor: on each falling edge, compare the outputs with the oldest expected entry.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("d_def", int'(d0), int'(e.d0));
        check("c_def", int'(c0), int'(e.c0));
        check("d_l4",  int'(d1), int'(e.d1));
        check("c_l4",  int'(c1), int'(e.c1));
        check("d_c2",  int'(d2), int'(e.d2));
        check("c_c2",  int'(c2), int'(e.c2));
      end
    end
  end

  initial begin
    rst = 1'b0; ina = 1'b0; in_valid = 1'b0; mode_ovl = 1'b0; cnt_clr = 1'b0;
`ifdef LZY_SEQDET_PROG_EN
    pat_load = 1'b0; pat_in3 = 3'b000; pat_in4 = 4'b0000;
`endif
    for (int k = 0; k < 3; k++) begin
      pat_m[k] = pdef_m[k]; nseen[k] = 0; cnt_m[k] = 0; d_m[k] = 1'b0;
    end

    // Reset held with live input, then released with two zeros.
    drive(0, 1, 1, 0, 0); drive(0, 0, 1, 0, 0); drive(0, 1, 1, 0, 0);
    drive(1, 0, 1, 0, 0); drive(1, 0, 1, 0, 0);

    // Default pattern, non-overlapping.
    stream(16'b100, 3, 1'b0);
    stream(16'b1100, 4, 1'b0);
    @(posedge clk); #1;
    check("t2_pulse", int'(d0), 1);
    check("t2_cnt", int'(c0), 2);

    // LEN=4 pattern 1010, first overlapping and then non-overlapping.
    drive(0, 0, 0, 0, 0);
    stream(16'b101010, 6, 1'b1);
    @(posedge clk); #1;
    check("t3_ovl_cnt", int'(c1), 2);
    drive(0, 0, 0, 0, 0);
    stream(16'b101010, 6, 1'b0);
    @(posedge clk); #1;
    check("t3_novl_cnt", int'(c1), 1);

    // Gaps in in_valid do not break a sequence.
    drive(0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 0); drive(1, 0, 0, 0, 0); drive(1, 1, 0, 0, 0);
    drive(1, 0, 1, 0, 0); drive(1, 1, 0, 0, 0); drive(1, 0, 1, 0, 0);
    @(posedge clk); #1;
    check("t4_gap_pulse", int'(d0), 1);
    drive(1, 0, 0, 0, 0);

    // Counter saturation, clear, and a clear on the same edge as a match.
    drive(0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) stream(16'b100, 3, 1'b0);
    @(posedge clk); #1;
    check("t5_sat", int'(c2), 3);
    drive(1, 0, 0, 0, 1);
    @(posedge clk); #1;
    check("t5_clr", int'(c2), 0);
    stream(16'b10, 2, 1'b0);
    drive(1, 0, 1, 0, 1);
    @(posedge clk); #1;
    check("t5_clr_match_d", int'(d2), 1);
    check("t5_clr_match_c", int'(c2), 0);

    // Reset asserted mid-pattern, between edges.
    stream(16'b100, 3, 1'b0);
    stream(16'b10, 2, 1'b0);
    drive(0, 0, 1, 0, 0);
    #1;
    check("t6_async_cnt", int'(c0), 0);
    check("t6_async_d", int'(d0), 0);
    drive(1, 0, 1, 0, 0);
    stream(16'b100, 3, 1'b0);
    @(posedge clk); #1;
    check("t6_restart_cnt", int'(c0), 1);

`ifdef LZY_SEQDET_PROG_EN
    // Load a new pattern, 011; the old pattern must no longer match.
    drive_load(3'b011, 4'b0110);
    stream(16'b011, 3, 1'b0);
    @(posedge clk); #1;
    check("t6_prog_pulse", int'(d0), 1);
    stream(16'b100, 3, 1'b0);
    drive(0, 0, 0, 0, 0);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
`ifdef LZY_SEQDET_PROG_EN
      if ($urandom_range(0, 49) == 0) begin
        drive_load(3'($urandom), 4'($urandom));
        continue;
      end
`endif
      drive(logic'($urandom_range(0, 99) != 0), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 1)),
            logic'($urandom_range(0, 29) == 0));
    end
    drive(1, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    check("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
